// File: rtl/sccb_responder_pkg.sv
// Shared types and constants for the SCCB responder and its line synchronizer.
package sccb_pkg;

    // Transaction-level states of the responder.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ID        = 4'd1,
        ST_ID_ACK    = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

    // Bit counter spans 0..8 (eight data bits plus the ninth/ack bit).
    localparam int                   BIT_CNT_W    = 4;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = 4'd7;
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX  = 4'd8;

    // ID byte layout: device ID in [7:1], R/W flag in bit 0 (1 = read).
    localparam int ID_RW_BIT  = 0;
    localparam int ID_DEV_LSB = 1;

    // Build an ID byte from a 7-bit device ID and the R/W flag.
    function automatic logic [7:0] sccb_id_byte(input logic [6:0] dev, input logic rw);
        return {dev, rw};
    endfunction

endpackage

// File: rtl/sccb_responder_line_sync.sv
// Synchronizes scl/sda into the system clock domain and detects scl edges
// plus bus START/STOP conditions. Idle bus level is high, so the flops
// reset to 1 to avoid spurious edges after reset.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_d_r;
    logic                   sda_d_r;
    logic                   scl_s;

    // Synchronizer chains followed by one delay flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_r <= {SYNC_STAGES{1'b1}};
            sda_sync_r <= {SYNC_STAGES{1'b1}};
            scl_d_r    <= 1'b1;
            sda_d_r    <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
            scl_d_r    <= scl_sync_r[SYNC_STAGES-1];
            sda_d_r    <= sda_sync_r[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync_r[SYNC_STAGES-1];
    assign sda_s     = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d_r;
    assign scl_fall  = ~scl_s & scl_d_r;
    // sda may only move while scl is stable high for a START/STOP.
    assign start_det = scl_s & scl_d_r & sda_d_r & ~sda_s;
    assign stop_det  = scl_s & scl_d_r & ~sda_d_r & sda_s;

endmodule

// File: rtl/sccb_responder.sv
// SCCB target emulating a camera sensor's 8-bit register file.
// Optional build macro SCCB_RESP_ACK_DRIVE_EN: when defined the responder
// pulls sda low during the ID/sub-address/write-data ack bits; otherwise the
// ninth bit is a don't-care and sda stays released.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = 7'h21,
    parameter int         REG_DEPTH   = 256,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       axi_clk,
    input  logic       axi_rst_n,
    input  logic       scl,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic       busy,
    output logic [7:0] sub_addr
);

`ifdef SCCB_RESP_ACK_DRIVE_EN
    localparam logic ACK_DRIVE = 1'b1;
`else
    localparam logic ACK_DRIVE = 1'b0;
`endif

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .clk       (axi_clk),
        .rst_n     (axi_rst_n),
        .scl       (scl),
        .sda       (sda_i),
        .sda_s     (sda_s),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    sccb_state_e          state_r, state_n;
    logic [BIT_CNT_W-1:0] bit_cnt_r, bit_cnt_n;
    logic [6:0]           shift_r, shift_n;
    logic [7:0]           sub_addr_r, sub_addr_n;
    logic                 busy_r, busy_n;
    logic                 sda_oe_r, sda_oe_n;
    logic [7:0]           rd_byte_r, rd_byte_n;
    logic                 wr_en_r, wr_en_n;
    logic [7:0]           wr_addr_r, wr_addr_n;
    logic [7:0]           wr_data_r, wr_data_n;
    logic [7:0]           regs_r [REG_DEPTH];
    logic [7:0]           rx_byte_s;
    logic [7:0]           rd_data_s;
    logic                 addr_ok_s;

    // Byte as it stands once the current bit is shifted in (MSB first).
    assign rx_byte_s = {shift_r, sda_s};
    assign addr_ok_s = (int'(sub_addr_r) < REG_DEPTH);

    // Register read mux; out-of-range sub-addresses read as zero.
    always_comb begin
        if (addr_ok_s) begin
            rd_data_s = regs_r[sub_addr_r];
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Next-state and output decode; START/STOP override any bit activity.
    always_comb begin
        state_n    = state_r;
        bit_cnt_n  = bit_cnt_r;
        shift_n    = shift_r;
        sub_addr_n = sub_addr_r;
        busy_n     = busy_r;
        sda_oe_n   = sda_oe_r;
        rd_byte_n  = rd_byte_r;
        wr_en_n    = 1'b0;
        wr_addr_n  = wr_addr_r;
        wr_data_n  = wr_data_r;
        if (start_det) begin
            state_n   = ST_ID;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
        end else if (stop_det) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 4'd0;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state_r)
                ST_ID, ST_SUB, ST_WDATA: begin
                    if (scl_rise) begin
                        shift_n = rx_byte_s[6:0];
                        if (bit_cnt_r == BIT_CNT_LAST) begin
                            bit_cnt_n = 4'd0;
                            if (state_r == ST_ID) begin
                                if (rx_byte_s[7:ID_DEV_LSB] == DEV_ID) begin
                                    busy_n  = 1'b1;
                                    state_n = ST_ID_ACK;
                                end else begin
                                    state_n = ST_IGNORE;
                                end
                            end else if (state_r == ST_SUB) begin
                                sub_addr_n = rx_byte_s;
                                state_n    = ST_SUB_ACK;
                            end else begin
                                wr_en_n   = 1'b1;
                                wr_addr_n = sub_addr_r;
                                wr_data_n = rx_byte_s;
                                state_n   = ST_WDATA_ACK;
                            end
                        end else begin
                            bit_cnt_n = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_ID_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    // First fall opens the ack bit, second fall closes it.
                    if (scl_fall) begin
                        if (bit_cnt_r == 4'd0) begin
                            sda_oe_n  = ACK_DRIVE;
                            bit_cnt_n = 4'd1;
                        end else begin
                            bit_cnt_n = 4'd0;
                            sda_oe_n  = 1'b0;
                            if (state_r == ST_ID_ACK) begin
                                if (shift_r[ID_RW_BIT]) begin
                                    state_n   = ST_RDATA;
                                    rd_byte_n = {rd_data_s[6:0], 1'b0};
                                    sda_oe_n  = ~rd_data_s[7];
                                    bit_cnt_n = 4'd1;
                                end else begin
                                    state_n = ST_SUB;
                                end
                            end else if (state_r == ST_SUB_ACK) begin
                                state_n = ST_WDATA;
                            end else begin
                                state_n = ST_IGNORE;
                            end
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_RDATA: begin
                    // bit_cnt counts bits already put on the bus.
                    if (scl_fall) begin
                        if (bit_cnt_r == BIT_CNT_MAX) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = ST_RDATA_ACK;
                        end else begin
                            sda_oe_n  = ~rd_byte_r[7];
                            rd_byte_n = {rd_byte_r[6:0], 1'b0};
                            bit_cnt_n = bit_cnt_r + 4'd1;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        shift_n = {shift_r[6:1], sda_s};
                    end else if (scl_fall) begin
                        if (!shift_r[0]) begin
                            state_n   = ST_RDATA;
                            rd_byte_n = {rd_data_s[6:0], 1'b0};
                            sda_oe_n  = ~rd_data_s[7];
                            bit_cnt_n = 4'd1;
                        end else begin
                            state_n  = ST_IGNORE;
                            sda_oe_n = 1'b0;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                default: begin
                    state_n  = state_r;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    // Protocol state and registered outputs.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 7'd0;
            sub_addr_r <= 8'h00;
            busy_r     <= 1'b0;
            sda_oe_r   <= 1'b0;
            rd_byte_r  <= 8'h00;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= 8'h00;
            wr_data_r  <= 8'h00;
        end else begin
            state_r    <= state_n;
            bit_cnt_r  <= bit_cnt_n;
            shift_r    <= shift_n;
            sub_addr_r <= sub_addr_n;
            busy_r     <= busy_n;
            sda_oe_r   <= sda_oe_n;
            rd_byte_r  <= rd_byte_n;
            wr_en_r    <= wr_en_n;
            wr_addr_r  <= wr_addr_n;
            wr_data_r  <= wr_data_n;
        end
    end

    // Register file; written on the same edge that raises reg_wr_en.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (wr_en_n && addr_ok_s) begin
            regs_r[sub_addr_r] <= rx_byte_s;
        end
    end

    assign sda_oe      = sda_oe_r;
    assign reg_wr_en   = wr_en_r;
    assign reg_wr_addr = wr_addr_r;
    assign reg_wr_data = wr_data_r;
    assign busy        = busy_r;
    assign sub_addr    = sub_addr_r;

endmodule

// File: tb/tb_sccb_responder.sv
// Bench for sccb_responder: a bit-banged SCCB master drives scl/sda, a
// scoreboard holds expected register commits and expected read bytes.
module tb_sccb_responder;

    localparam int H = 4;

    logic       axi_clk   = 1'b0;
    logic       axi_rst_n = 1'b0;
    logic       scl       = 1'b1;
    logic       sda_m     = 1'b1;
    logic       sda_i;
    logic       sda_oe, reg_wr_en, busy;
    logic [7:0] reg_wr_addr, reg_wr_data, sub_addr;

    int         total = 0;
    int         bad   = 0;
    logic [15:0] wr_q [$];
    logic [7:0]  rd_q [$];
    logic [7:0]  model_mem [256];
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;
    logic        wr_en_prev = 1'b0;

`ifdef SCCB_RESP_ACK_DRIVE_EN
    localparam logic EXP_ACK = 1'b0;
`else
    localparam logic EXP_ACK = 1'b1;
`endif

    // Open-drain bus: low if either side pulls it.
    assign sda_i = sda_m & ~sda_oe;

    sccb_responder dut (
        .axi_clk     (axi_clk),
        .axi_rst_n   (axi_rst_n),
        .scl         (scl),
        .sda_i       (sda_i),
        .sda_oe      (sda_oe),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .busy        (busy),
        .sub_addr    (sub_addr)
    );

    always #5 axi_clk = ~axi_clk;

    // Commit monitor: every reg_wr_en pulse must match the scoreboard head.
    always @(negedge axi_clk) begin
        if (!axi_rst_n) begin
            wr_en_prev = 1'b0;
        end else begin
            if (sda_oe) oe_seen = 1'b1;
            if (busy) busy_seen = 1'b1;
            if (reg_wr_en) begin
                total++;
                if (wr_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected got addr=%h data=%h exp none", reg_wr_addr, reg_wr_data);
                end else begin
                    logic [15:0] e;
                    e = wr_q.pop_front();
                    if ({reg_wr_addr, reg_wr_data} !== e) begin
                        bad++;
                        $display("FAIL wr_commit got=%h exp=%h", {reg_wr_addr, reg_wr_data}, e);
                    end
                end
                total++;
                if (wr_en_prev !== 1'b0) begin
                    bad++;
                    $display("FAIL wr_pulse_width got=2+ cycles exp=1");
                end
            end
            wr_en_prev = reg_wr_en;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge axi_clk);
    endtask

    task automatic m_start();
        sda_m = 1'b1; tick(H);
        scl = 1'b1;   tick(H);
        sda_m = 1'b0; tick(H);
        scl = 1'b0;   tick(H);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; tick(H);
        scl = 1'b1;   tick(H);
        sda_m = 1'b1; tick(2*H);
    endtask

    task automatic m_bit(input logic b, output logic r);
        sda_m = b;  tick(H);
        scl = 1'b1; tick(H);
        r = sda_i;  tick(H);
        scl = 1'b0; tick(H);
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(b[i], r);
        m_bit(1'b1, ack);
    endtask

    task automatic m_read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
        end
        m_bit(mack, r);
    endtask

    // Point at addr with a 2-phase write, then read one byte with NA.
    task automatic m_read_reg(input logic [7:0] a, output logic [7:0] d);
        logic k;
        m_start(); m_write_byte(8'h42, k); m_write_byte(a, k); m_stop();
        m_start(); m_write_byte(8'h43, k); m_read_byte(1'b1, d); m_stop();
    endtask

    task automatic test_reset();
        axi_rst_n = 1'b0;
        tick(3);
        total++;
        if ({sda_oe, reg_wr_en, busy, reg_wr_addr, reg_wr_data, sub_addr} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {sda_oe, reg_wr_en, busy, reg_wr_addr, reg_wr_data, sub_addr});
        end
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        axi_rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_write3();
        logic a0, a1, a2;
        m_start();
        m_write_byte(8'h42, a0);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_id got=%b exp=1", busy); end
        m_write_byte(8'h1A, a1);
        wr_q.push_back({8'h1A, 8'h5C});
        model_mem[8'h1A] = 8'h5C;
        m_write_byte(8'h5C, a2);
        total++;
        if ({a0, a1, a2} !== {3{EXP_ACK}}) begin
            bad++; $display("FAIL write_acks got=%b exp=%b", {a0, a1, a2}, {3{EXP_ACK}});
        end
        total++;
        if ({reg_wr_addr, reg_wr_data, sub_addr} !== 24'h1A5C1A) begin
            bad++; $display("FAIL write_regs got=%h exp=1a5c1a", {reg_wr_addr, reg_wr_data, sub_addr});
        end
        // STOP with busy timing: two sync flops, then busy falls one cycle later.
        sda_m = 1'b0; tick(H);
        scl = 1'b1;   tick(H);
        sda_m = 1'b1; tick(2);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_at_stop_det got=%b exp=1", busy); end
        tick(1);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_after_stop got=%b exp=0", busy); end
        tick(2*H);
    endtask

    task automatic test_read_2phase();
        logic k, a;
        logic [7:0] d, e;
        m_start(); m_write_byte(8'h42, k); m_write_byte(8'h1A, k); m_stop();
        total++;
        if (sub_addr !== 8'h1A) begin bad++; $display("FAIL sub_addr_2phase got=%h exp=1a", sub_addr); end
        m_start(); m_write_byte(8'h43, a);
        total++;
        if (a !== EXP_ACK) begin bad++; $display("FAIL read_id_ack got=%b exp=%b", a, EXP_ACK); end
        rd_q.push_back(model_mem[8'h1A]);
        m_read_byte(1'b1, d);
        e = rd_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL read_data got=%h exp=%h", d, e); end
        total++;
        if (sda_oe !== 1'b0) begin bad++; $display("FAIL read_na_release got=%b exp=0", sda_oe); end
        m_stop();
        total++;
        if ({sda_oe, busy} !== 2'b00) begin bad++; $display("FAIL read_end got=%b exp=00", {sda_oe, busy}); end
    endtask

    task automatic test_wrong_id();
        logic k;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        m_start(); m_write_byte(8'h60, k); m_write_byte(8'h11, k); m_write_byte(8'h22, k); m_stop();
        total++;
        if ({oe_seen, busy_seen} !== 2'b00) begin
            bad++; $display("FAIL wrong_id_quiet got oe/busy=%b exp=00", {oe_seen, busy_seen});
        end
    endtask

    task automatic test_partial_stop();
        logic k;
        logic [7:0] d, e;
        m_start(); m_write_byte(8'h42, k); m_write_byte(8'h1A, k);
        for (int i = 0; i < 4; i++) m_bit(1'b1, k);
        m_stop();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL partial_busy got=%b exp=0", busy); end
        rd_q.push_back(model_mem[8'h1A]);
        m_read_reg(8'h1A, d);
        e = rd_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL partial_unchanged got=%h exp=%h", d, e); end
        wr_q.push_back({8'h1A, 8'h77});
        model_mem[8'h1A] = 8'h77;
        m_start(); m_write_byte(8'h42, k); m_write_byte(8'h1A, k); m_write_byte(8'h77, k); m_stop();
        rd_q.push_back(model_mem[8'h1A]);
        m_read_reg(8'h1A, d);
        e = rd_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL partial_next_write got=%h exp=%h", d, e); end
    endtask

    task automatic test_rep_start();
        logic a0, a1, a2;
        logic [7:0] d, e;
        m_start(); m_write_byte(8'h42, a0); m_write_byte(8'h0B, a1);
        m_start(); m_write_byte(8'h43, a2);
        rd_q.push_back(model_mem[8'h0B]);
        m_read_byte(1'b1, d);
        m_stop();
        e = rd_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL rep_start_data got=%h exp=%h", d, e); end
        total++;
        if ({a0, a1, a2} !== {3{EXP_ACK}}) begin
            bad++; $display("FAIL rep_start_acks got=%b exp=%b", {a0, a1, a2}, {3{EXP_ACK}});
        end
    endtask

    task automatic test_back_to_back();
        logic k;
        logic [7:0] d0, d1, e;
        m_start(); m_write_byte(8'h42, k); m_write_byte(8'h1A, k); m_stop();
        m_start(); m_write_byte(8'h43, k);
        rd_q.push_back(model_mem[8'h1A]);
        rd_q.push_back(model_mem[8'h1A]);
        m_read_byte(1'b0, d0);
        m_read_byte(1'b1, d1);
        m_stop();
        e = rd_q.pop_front();
        total++;
        if (d0 !== e) begin bad++; $display("FAIL resend_first got=%h exp=%h", d0, e); end
        e = rd_q.pop_front();
        total++;
        if (d1 !== e) begin bad++; $display("FAIL resend_second got=%h exp=%h", d1, e); end
    endtask

    task automatic test_reset_mid();
        logic k;
        logic [7:0] d, e;
        m_start(); m_write_byte(8'h42, k); m_write_byte(8'h1A, k); m_stop();
        m_start(); m_write_byte(8'h43, k);
        // reg[0x1A]=0x77: its MSB is 0, so the responder is pulling sda now.
        total++;
        if (sda_oe !== ~model_mem[8'h1A][7]) begin
            bad++; $display("FAIL mid_read_drive got=%b exp=%b", sda_oe, ~model_mem[8'h1A][7]);
        end
        #2 axi_rst_n = 1'b0;
        #1;
        total++;
        if (sda_oe !== 1'b0) begin bad++; $display("FAIL async_release got=%b exp=0", sda_oe); end
        tick(2);
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
        axi_rst_n = 1'b1;
        m_stop();
        total++;
        if ({busy, sub_addr} !== 9'd0) begin
            bad++; $display("FAIL after_reset_state got=%h exp=0", {busy, sub_addr});
        end
        rd_q.push_back(model_mem[8'h1A]);
        m_read_reg(8'h1A, d);
        e = rd_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL reset_cleared_reg got=%h exp=%h", d, e); end
        wr_q.push_back({8'h05, 8'hA5});
        model_mem[8'h05] = 8'hA5;
        m_start(); m_write_byte(8'h42, k); m_write_byte(8'h05, k); m_write_byte(8'hA5, k); m_stop();
        rd_q.push_back(model_mem[8'h05]);
        m_read_reg(8'h05, d);
        e = rd_q.pop_front();
        total++;
        if (d !== e) begin bad++; $display("FAIL write_after_reset got=%h exp=%h", d, e); end
    endtask

    initial begin
        test_reset();
        test_write3();
        test_read_2phase();
        test_wrong_id();
        test_partial_stop();
        test_rep_start();
        test_back_to_back();
        test_reset_mid();
        tick(4);
        total++;
        if (wr_q.size() != 0) begin
            bad++; $display("FAIL missing_commits got=%0d pending exp=0", wr_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
